// File: rtl/sensor_bus_arbiter_pkg.sv
// Shared types and constants for the sensor/display bus arbiter.
// State encodings double as the debug state output.
package sensor_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_START = 2'b01,
        ARB_BUSY  = 2'b10,
        ARB_GAP   = 2'b11
    } arb_state_t;

    localparam logic REQ_C1 = 1'b0;
    localparam logic REQ_C2 = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_GAP_CYCLES     = 4;

endpackage

// File: rtl/sensor_bus_arbiter_if.sv
// Handshake bundle between the requesters/bus engine and the arbiter.
// master = requester and engine side, slave = arbiter side.
interface sensor_bus_arbiter_if #(
    parameter int ERR_W = 8
);
    logic             req_c1;
    logic             req_c2;
    logic             done;
    logic             grant_c1;
    logic             grant_c2;
    logic             sel;
    logic             start;
    logic             done_c1;
    logic             done_c2;
    logic             timeout;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state;

    modport master (
        output req_c1, req_c2, done,
        input  grant_c1, grant_c2, sel, start, done_c1, done_c2, timeout, err_cnt, state
    );

    modport slave (
        input  req_c1, req_c2, done,
        output grant_c1, grant_c2, sel, start, done_c1, done_c2, timeout, err_cnt, state
    );
endinterface

// File: rtl/sensor_bus_arbiter_timer.sv
// Cycle counter with synchronous clear, enable and terminal-count compare.
// Used for both the per-transaction timeout and the inter-transaction gap.
module arb_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == tc_val);
endmodule

// File: rtl/sensor_bus_arbiter.sv
// Round-robin arbiter sharing one bus engine between C1 (temperature read)
// and C2 (device connect/config), with timeout abort and idle guard gap.
//
//  state     | meaning
//  ----------+-------------------------------------------------
//  ARB_IDLE  | no owner, waiting for a request
//  ARB_START | grant issued, start pulse to the bus engine
//  ARB_BUSY  | waiting for engine done, timeout counter running
//  ARB_GAP   | guard gap after a transaction, requests held off
module sensor_bus_arbiter
    import sensor_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TMR_W          = 10,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int GAP_W          = 3,
    parameter int ERR_W          = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    sensor_bus_arbiter_if.slave bus
);
    localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_TC = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam arb_state_t       POST_STATE = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;

    arb_state_t       state_q, state_d;
    logic             grant_c1_q, grant_c1_d;
    logic             grant_c2_q, grant_c2_d;
    logic             sel_q, sel_d;
    logic             start_q, start_d;
    logic             done_c1_q, done_c1_d;
    logic             done_c2_q, done_c2_d;
    logic             timeout_q, timeout_d;
    logic             last_q, last_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             winner;
    logic             tmr_tc;
    logic             gap_tc;

    arb_cycle_timer #(.W(TMR_W)) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != ARB_BUSY),
        .en     (state_q == ARB_BUSY),
        .tc_val (TMR_TC),
        .tc     (tmr_tc)
    );

    arb_cycle_timer #(.W(GAP_W)) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != ARB_GAP),
        .en     (state_q == ARB_GAP),
        .tc_val (GAP_TC),
        .tc     (gap_tc)
    );

    // On a tie the requester that did not win last time gets the bus.
    assign winner = (bus.req_c1 && bus.req_c2) ? ~last_q : bus.req_c2;

    always_comb begin
        state_d    = state_q;
        grant_c1_d = grant_c1_q;
        grant_c2_d = grant_c2_q;
        sel_d      = sel_q;
        last_d     = last_q;
        err_d      = err_q;
        start_d    = 1'b0;
        done_c1_d  = 1'b0;
        done_c2_d  = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (bus.req_c1 || bus.req_c2) begin
                    state_d    = ARB_START;
                    grant_c1_d = (winner == REQ_C1);
                    grant_c2_d = (winner == REQ_C2);
                    sel_d      = winner;
                    last_d     = winner;
                    start_d    = 1'b1;
                end
            end
            ARB_START: state_d = ARB_BUSY;
            ARB_BUSY: begin
                if (bus.done) begin
                    done_c1_d  = (sel_q == REQ_C1);
                    done_c2_d  = (sel_q == REQ_C2);
                    grant_c1_d = 1'b0;
                    grant_c2_d = 1'b0;
                    state_d    = POST_STATE;
                end else if (tmr_tc) begin
                    timeout_d  = 1'b1;
                    grant_c1_d = 1'b0;
                    grant_c2_d = 1'b0;
                    err_d      = (err_q == '1) ? err_q : err_q + ERR_W'(1);
                    state_d    = POST_STATE;
                end
            end
            ARB_GAP: begin
                if (gap_tc) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_c1_q <= 1'b0;
            grant_c2_q <= 1'b0;
            sel_q      <= 1'b0;
            start_q    <= 1'b0;
            done_c1_q  <= 1'b0;
            done_c2_q  <= 1'b0;
            timeout_q  <= 1'b0;
            last_q     <= REQ_C2;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_c1_q <= grant_c1_d;
            grant_c2_q <= grant_c2_d;
            sel_q      <= sel_d;
            start_q    <= start_d;
            done_c1_q  <= done_c1_d;
            done_c2_q  <= done_c2_d;
            timeout_q  <= timeout_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    assign bus.grant_c1 = grant_c1_q;
    assign bus.grant_c2 = grant_c2_q;
    assign bus.sel      = sel_q;
    assign bus.start    = start_q;
    assign bus.done_c1  = done_c1_q;
    assign bus.done_c2  = done_c2_q;
    assign bus.timeout  = timeout_q;
    assign bus.err_cnt  = err_q;
    assign bus.state    = state_q;
endmodule
